// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared port indices, widths and FSM encoding for the router link
`ifndef SIZE
`define SIZE 8
`endif

package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int DEST_W    = 4;

    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_NORTH = 3'd1;
    localparam logic [2:0] PORT_EAST  = 3'd2;
    localparam logic [2:0] PORT_SOUTH = 3'd3;
    localparam logic [2:0] PORT_WEST  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } tx_state_e;

    // One-hot mask for a port index; indices outside the port range give 0.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [2:0] port);
        logic [NUM_PORTS-1:0] mask;
        mask = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (port == 3'(k)) begin
                mask[k] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/tx_logic_if.sv
// rtl/tx_logic_if.sv - FIFO pop side and 5-port toggle req/ack link bundle
`ifndef SIZE
`define SIZE 8
`endif

interface tx_logic_if #(
    parameter int SIZE = `SIZE
) ();
    import noc_pkg::*;

    logic                        fifo_read;
    logic                        fifo_empty;
    logic [SIZE-1:0]             fifo_data_out;
    logic [NUM_PORTS-1:0]        tx_req;
    logic [NUM_PORTS-1:0]        tx_ack;
    logic [SIZE*NUM_PORTS-1:0]   tx_data;

    modport master (
        output fifo_read,
        input  fifo_empty,
        input  fifo_data_out,
        output tx_req,
        input  tx_ack,
        output tx_data
    );

    modport slave (
        input  fifo_read,
        output fifo_empty,
        output fifo_data_out,
        input  tx_req,
        output tx_ack,
        input  tx_data
    );

endinterface

// File: rtl/tx_logic_xy_route.sv
// rtl/tx_logic_xy_route.sv - combinational XY (X first, then Y) output port selection
module xy_route
    import noc_pkg::*;
#(
    parameter int ID   = -1,
    parameter int COLS = 4
) (
    input  logic [DEST_W-1:0] i_dest,
    output logic [2:0]        o_port
);

    localparam int X = ID % COLS;
    localparam int Y = ID / COLS;

    int w_dx;
    int w_dy;

    assign w_dx = int'(i_dest) % COLS;
    assign w_dy = int'(i_dest) / COLS;

    // Column is resolved before row, so a packet never turns from Y back to X.
    always_comb begin
        o_port = PORT_LOCAL;
        if (w_dx > X) begin
            o_port = PORT_EAST;
        end else if (w_dx < X) begin
            o_port = PORT_WEST;
        end else if (w_dy < Y) begin
            o_port = PORT_NORTH;
        end else if (w_dy > Y) begin
            o_port = PORT_SOUTH;
        end
    end

endmodule

// File: rtl/tx_logic.sv
// rtl/tx_logic.sv - pops the output FIFO, routes XY, sends over per-port toggle handshake; TX_ACK_SYNC_EN adds 2-flop ack synchronisers
module tx_logic
    import noc_pkg::*;
#(
    parameter int id   = -1,
    parameter int COLS = 4,
    parameter int SIZE = `SIZE
) (
    input  logic          clk,
    input  logic          reset,
    tx_logic_if.master    bus
);

    tx_state_e                   r_state;
    tx_state_e                   w_state_nxt;
    logic                        r_fifo_read;
    logic                        w_fifo_read_nxt;
    logic [SIZE-1:0]             r_item;
    logic [SIZE-1:0]             w_item_nxt;
    logic [2:0]                  r_sel;
    logic [2:0]                  w_sel_nxt;
    logic [NUM_PORTS-1:0]        r_req;
    logic [NUM_PORTS-1:0]        w_req_nxt;
    logic [SIZE*NUM_PORTS-1:0]   r_data;
    logic [SIZE*NUM_PORTS-1:0]   w_data_nxt;

    logic [NUM_PORTS-1:0]        w_ack_s;
    logic [NUM_PORTS-1:0]        w_pend;
    logic [NUM_PORTS-1:0]        w_sel_mask;
    logic                        w_sel_busy;
    logic [2:0]                  w_route_port;

`ifdef TX_ACK_SYNC_EN
    logic [NUM_PORTS-1:0]        r_ack_s1;
    logic [NUM_PORTS-1:0]        r_ack_s2;

    // Two-stage synchroniser per ack bit for a receiver on a foreign clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ack_s1 <= '0;
            r_ack_s2 <= '0;
        end else begin
            r_ack_s1 <= bus.tx_ack;
            r_ack_s2 <= r_ack_s1;
        end
    end

    assign w_ack_s = r_ack_s2;
`else
    assign w_ack_s = bus.tx_ack;
`endif

    // A port is busy from its req toggle until the matching ack toggle.
    assign w_pend     = r_req ^ w_ack_s;
    assign w_sel_mask = port_onehot(r_sel);
    assign w_sel_busy = |(w_pend & w_sel_mask);

    xy_route #(
        .ID   (id),
        .COLS (COLS)
    ) u_xy_route (
        .i_dest (bus.fifo_data_out[SIZE-1 -: DEST_W]),
        .o_port (w_route_port)
    );

    // State and every output are registered, so acks never reach req combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_fifo_read <= 1'b0;
            r_item      <= '0;
            r_sel       <= PORT_LOCAL;
            r_req       <= '0;
            r_data      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fifo_read <= w_fifo_read_nxt;
            r_item      <= w_item_nxt;
            r_sel       <= w_sel_nxt;
            r_req       <= w_req_nxt;
            r_data      <= w_data_nxt;
        end
    end

    // Next state: pop, latch head and route, then send once the chosen port is free.
    always_comb begin
        w_state_nxt     = r_state;
        w_fifo_read_nxt = 1'b0;
        w_item_nxt      = r_item;
        w_sel_nxt       = r_sel;
        w_req_nxt       = r_req;
        w_data_nxt      = r_data;

        case (r_state)
            ST_IDLE: begin
                if (!bus.fifo_empty) begin
                    w_fifo_read_nxt = 1'b1;
                    w_state_nxt     = ST_FETCH;
                end
            end

            ST_FETCH: begin
                w_item_nxt  = bus.fifo_data_out;
                w_sel_nxt   = w_route_port;
                w_state_nxt = ST_HOLD;
            end

            ST_HOLD: begin
                // A busy port blocks the head item; no further pops meanwhile.
                if (!w_sel_busy) begin
                    w_req_nxt = r_req ^ w_sel_mask;
                    for (int k = 0; k < NUM_PORTS; k++) begin
                        if (w_sel_mask[k]) begin
                            w_data_nxt[SIZE*k +: SIZE] = r_item;
                        end
                    end
                    if (!bus.fifo_empty) begin
                        w_fifo_read_nxt = 1'b1;
                        w_state_nxt     = ST_FETCH;
                    end else begin
                        w_state_nxt     = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.fifo_read = r_fifo_read;
    assign bus.tx_req    = r_req;
    assign bus.tx_data   = r_data;

endmodule

// File: tb/tb_tx_logic.sv
// tb/tb_tx_logic.sv - directed bench for tx_logic (id=5, COLS=4, SIZE=8)
`timescale 1ns/1ps

module tb_tx_logic;

`ifdef TX_ACK_SYNC_EN
    localparam int ACK_LAT = 3;
`else
    localparam int ACK_LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    logic [7:0] mem [0:15];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    tx_logic_if #(.SIZE(8)) bus ();

    tx_logic #(
        .id   (5),
        .COLS (4),
        .SIZE (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.fifo_empty    = (wr_ptr == rd_ptr);
    assign bus.fifo_data_out = mem[rd_ptr[3:0]];

    always @(posedge clk) begin
        if (bus.fifo_read && !bus.fifo_empty) begin
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[3:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        reset      = 1'b0;
        bus.tx_ack = 5'b00000;
        repeat (3) step();
        check("rst_req",  64'(bus.tx_req),    64'h0);
        check("rst_data", 64'(bus.tx_data),   64'h0);
        check("rst_read", 64'(bus.fifo_read), 64'h0);
        reset = 1'b1;
        step();
        check("idle_read", 64'(bus.fifo_read), 64'h0);

        // dest 6 from router 5 goes east; three edges to the req toggle
        push(8'h6A);
        step();
        check("t1_read_e1", 64'(bus.fifo_read), 64'h1);
        step();
        check("t1_read_e2", 64'(bus.fifo_read), 64'h0);
        check("t1_req_e2",  64'(bus.tx_req),    64'h0);
        step();
        check("t1_req_e3",  64'(bus.tx_req),          64'h04);
        check("t1_data_e3", 64'(bus.tx_data[23:16]),  64'h6A);
        bus.tx_ack = 5'b00100;
        step();
        check("t1_pend2", 64'(bus.tx_req ^ bus.tx_ack), 64'h0);

        // dest 5 local (never acked), then dest 1 north two cycles later
        push(8'h51);
        push(8'h1C);
        step();
        check("t2_read_e1", 64'(bus.fifo_read), 64'h1);
        step();
        step();
        check("t2_req_e3",  64'(bus.tx_req),        64'h05);
        check("t2_d0_e3",   64'(bus.tx_data[7:0]),  64'h51);
        check("t2_read_e3", 64'(bus.fifo_read),     64'h1);
        step();
        step();
        check("t2_req_e5",  64'(bus.tx_req),         64'h07);
        check("t2_d1_e5",   64'(bus.tx_data[15:8]),  64'h1C);
        check("t2_d0_e5",   64'(bus.tx_data[7:0]),   64'h51);
        check("t2_read_e5", 64'(bus.fifo_read),      64'h0);

        // two items west with port 4 busy: head-of-line block until ack
        push(8'h4A);
        push(8'h4B);
        step();
        step();
        step();
        check("t3_req_e3",  64'(bus.tx_req),          64'h17);
        check("t3_d4_e3",   64'(bus.tx_data[39:32]),  64'h4A);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_hold_read", 64'(bus.fifo_read), 64'h0);
            check("t3_hold_req",  64'(bus.tx_req),    64'h17);
        end
        bus.tx_ack = 5'b10100;
        for (int i = 0; i < ACK_LAT - 1; i++) begin
            step();
            check("t3_ack_wait", 64'(bus.tx_req), 64'h17);
        end
        step();
        check("t3_req_ack", 64'(bus.tx_req),         64'h07);
        check("t3_d4_ack",  64'(bus.tx_data[39:32]), 64'h4B);

        // reset while held in HOLD with port 2 pending
        push(8'h6B);
        push(8'h6C);
        step();
        step();
        step();
        check("t4_req_e3", 64'(bus.tx_req),         64'h03);
        check("t4_d2_e3",  64'(bus.tx_data[23:16]), 64'h6B);
        step();
        step();
        check("t4_blk_req",  64'(bus.tx_req),    64'h03);
        check("t4_blk_read", 64'(bus.fifo_read), 64'h0);
        reset      = 1'b0;
        bus.tx_ack = 5'b00000;
        #1;
        check("t4_async_req",  64'(bus.tx_req),    64'h0);
        check("t4_async_data", 64'(bus.tx_data),   64'h0);
        check("t4_async_read", 64'(bus.fifo_read), 64'h0);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("t4_quiet_req",  64'(bus.tx_req),    64'h0);
            check("t4_quiet_read", 64'(bus.fifo_read), 64'h0);
        end
        push(8'h6D);
        step();
        step();
        step();
        check("t4_req_new",  64'(bus.tx_req),  64'h04);
        check("t4_data_new", 64'(bus.tx_data), 64'h00006D0000);
        bus.tx_ack = 5'b00100;

        // empty FIFO for 20 cycles
        for (int i = 0; i < 20; i++) begin
            step();
            check("t5_read", 64'(bus.fifo_read), 64'h0);
            check("t5_req",  64'(bus.tx_req),    64'h04);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
